fns_decoder_5b: RTL and testbench



---
 rtl/fns_pkg.sv | 17 +
 rtl/fns_decoder_5b_if.sv | 38 +++
 rtl/fns_weight_mux.sv | 26 ++
 rtl/fns_decoder_5b.sv | 133 +++++++++++++
 tb/tb_fns_decoder_5b.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/fns_pkg.sv
// Shared constants and types for the 5-TSV FNS coder/decoder pair.
package fns_pkg;

   localparam int unsigned CODE_W     = 5;
   localparam int unsigned IDX_W      = 3;
   localparam int unsigned FNS_W_LEN  = 4;
   localparam int unsigned FNS_DATA_W = 4;

   localparam logic [IDX_W-1:0] IDX_START = IDX_W'(CODE_W - 1);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StAcc  = 2'd1,
      StDone = 2'd2
   } fns_dec_state_e;

endpackage

// File: rtl/fns_decoder_5b_if.sv
// Codeword-in / data-out handshake bundle of the FNS decoder.
// FNS_DEC_FAULT_CHECK_EN adds the fault_err signal.
interface fns_decoder_5b_if
   import fns_pkg::*;
#(
   parameter int unsigned DATA_W = FNS_DATA_W
);
   logic [CODE_W-1:0] code_in;
   logic [CODE_W-1:0] en_flag;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] data_out;
   logic              out_valid;
   logic              out_ready;

`ifdef FNS_DEC_FAULT_CHECK_EN
   logic              fault_err;

   modport master (
      output code_in, en_flag, in_valid, out_ready,
      input  in_ready, data_out, out_valid, fault_err
   );
   modport slave (
      input  code_in, en_flag, in_valid, out_ready,
      output in_ready, data_out, out_valid, fault_err
   );
`else
   modport master (
      output code_in, en_flag, in_valid, out_ready,
      input  in_ready, data_out, out_valid
   );
   modport slave (
      input  code_in, en_flag, in_valid, out_ready,
      output in_ready, data_out, out_valid
   );
`endif

endinterface

// File: rtl/fns_weight_mux.sv
// Selects the FNS weight for one codeword bit; bit 0 always weighs 1.
module fns_weight_mux
   import fns_pkg::*;
#(
   parameter int unsigned W_LEN = FNS_W_LEN
) (
   input  logic [IDX_W-1:0] idx_i,
   input  logic [W_LEN-1:0] fns02_i,
   input  logic [W_LEN-1:0] fns03_i,
   input  logic [W_LEN-1:0] fns04_i,
   input  logic [W_LEN-1:0] fns05_i,
   output logic [W_LEN-1:0] w_o
);

   always_comb begin
      w_o = W_LEN'(1);
      case (idx_i)
         3'd1:    w_o = fns02_i;
         3'd2:    w_o = fns03_i;
         3'd3:    w_o = fns04_i;
         3'd4:    w_o = fns05_i;
         default: w_o = W_LEN'(1);
      endcase
   end

endmodule

// File: rtl/fns_decoder_5b.sv
// Bit-serial FNS decoder: masked weighted sum of the codeword, MSB first, 5 cycles per word.
// Optional FNS_DEC_FAULT_CHECK_EN flags codeword ones landing on disabled TSVs.
module fns_decoder_5b
   import fns_pkg::*;
#(
   parameter int unsigned DATA_W = FNS_DATA_W,
   parameter int unsigned W_LEN  = FNS_W_LEN
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic [W_LEN-1:0] FNS02,
   input  logic [W_LEN-1:0] FNS03,
   input  logic [W_LEN-1:0] FNS04,
   input  logic [W_LEN-1:0] FNS05,
   fns_decoder_5b_if.slave  bus_io
);

   fns_dec_state_e    state_q;
   logic [CODE_W-1:0] mask_q;
   logic [IDX_W-1:0]  idx_q;
   logic [DATA_W-1:0] acc_q;
   logic [DATA_W-1:0] data_q;
   logic              in_ready_q;
   logic              out_valid_q;
   logic [W_LEN-1:0]  w2_q, w3_q, w4_q, w5_q;

   logic [W_LEN-1:0]  w_sel;
   logic [DATA_W-1:0] acc_nxt;
   logic              accept;
   logic              last_step;
   logic              release_word;

   assign accept       = (state_q == StIdle) && bus_io.in_valid && in_ready_q;
   assign last_step    = (state_q == StAcc) && (idx_q == '0);
   assign release_word = (state_q == StDone) && bus_io.out_ready;

   fns_weight_mux #(
      .W_LEN(W_LEN)
   ) u_weight_mux (
      .idx_i  (idx_q),
      .fns02_i(w2_q),
      .fns03_i(w3_q),
      .fns04_i(w4_q),
      .fns05_i(w5_q),
      .w_o    (w_sel)
   );

   // Weight is zero-extended or truncated to DATA_W; the sum wraps silently.
   assign acc_nxt = mask_q[idx_q] ? acc_q + DATA_W'(w_sel) : acc_q;

   always_ff @(posedge clock) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         mask_q      <= '0;
         idx_q       <= IDX_START;
         acc_q       <= '0;
         data_q      <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         w2_q        <= '0;
         w3_q        <= '0;
         w4_q        <= '0;
         w5_q        <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  mask_q     <= bus_io.code_in & bus_io.en_flag;
                  acc_q      <= '0;
                  idx_q      <= IDX_START;
                  w2_q       <= FNS02;
                  w3_q       <= FNS03;
                  w4_q       <= FNS04;
                  w5_q       <= FNS05;
                  in_ready_q <= 1'b0;
                  state_q    <= StAcc;
               end
            end
            StAcc: begin
               acc_q <= acc_nxt;
               if (last_step) begin
                  data_q      <= acc_nxt;
                  out_valid_q <= 1'b1;
                  state_q     <= StDone;
               end else begin
                  idx_q <= idx_q - 1'b1;
               end
            end
            StDone: begin
               if (release_word) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= StIdle;
               end
            end
            default: begin
               state_q     <= StIdle;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus_io.in_ready  = in_ready_q;
   assign bus_io.out_valid = out_valid_q;
   assign bus_io.data_out  = data_q;

`ifdef FNS_DEC_FAULT_CHECK_EN
   logic fault_cap_q;
   logic fault_err_q;

   // Captured with the word, presented together with out_valid.
   always_ff @(posedge clock) begin
      if (!rst_n) begin
         fault_cap_q <= 1'b0;
         fault_err_q <= 1'b0;
      end else begin
         if (accept) begin
            fault_cap_q <= |(bus_io.code_in & ~bus_io.en_flag);
         end
         if (last_step) begin
            fault_err_q <= fault_cap_q;
         end else if (release_word) begin
            fault_err_q <= 1'b0;
         end
      end
   end

   assign bus_io.fault_err = fault_err_q;
`endif

endmodule

// File: tb/tb_fns_decoder_5b.sv
// Directed bench for fns_decoder_5b with a cycle-level behavioural model and per-cycle compare.
module tb_fns_decoder_5b;

   logic       clock = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] f2 = 4'd1, f3 = 4'd2, f4 = 4'd3, f5 = 4'd5;

   int nchk = 0;
   int nerr = 0;

   fns_decoder_5b_if #(.DATA_W(4)) intf ();
   fns_decoder_5b_if #(.DATA_W(3)) intf3 ();

   fns_decoder_5b #(.DATA_W(4), .W_LEN(4)) dut (
      .clock (clock),
      .rst_n (rst_n),
      .FNS02 (f2),
      .FNS03 (f3),
      .FNS04 (f4),
      .FNS05 (f5),
      .bus_io(intf.slave)
   );

   fns_decoder_5b #(.DATA_W(3), .W_LEN(4)) dut3 (
      .clock (clock),
      .rst_n (rst_n),
      .FNS02 (f2),
      .FNS03 (f3),
      .FNS04 (f4),
      .FNS05 (f5),
      .bus_io(intf3.slave)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: decoded value straight from the FNS definition.
   function automatic int fns_value(input logic [4:0] c, input logic [4:0] e, input int dw);
      int w[5];
      int s;
      w[0] = 1;
      w[1] = int'(f2);
      w[2] = int'(f3);
      w[3] = int'(f4);
      w[4] = int'(f5);
      s = 0;
      for (int i = 0; i < 5; i++) if (c[i] && e[i]) s += w[i];
      return s % (1 << dw);
   endfunction

   int exp_ready = 1, exp_valid = 0, exp_data = 0, exp_fault = 0;
   int pend_data = 0, pend_fault = 0, busy = 0;

   always @(posedge clock) begin
      if (!rst_n) begin
         exp_ready = 1; exp_valid = 0; exp_data = 0; exp_fault = 0; busy = 0;
      end else if (exp_ready == 1 && intf.in_valid) begin
         pend_data  = fns_value(intf.code_in, intf.en_flag, 4);
         pend_fault = int'(|(intf.code_in & ~intf.en_flag));
         exp_ready  = 0;
         busy       = 5;
      end else if (busy > 0) begin
         busy--;
         if (busy == 0) begin
            exp_valid = 1; exp_data = pend_data; exp_fault = pend_fault;
         end
      end else if (exp_valid == 1 && intf.out_ready) begin
         exp_valid = 0; exp_ready = 1; exp_fault = 0;
      end
   end

   always @(negedge clock) begin
      check("cmp_in_ready", int'(intf.in_ready), exp_ready);
      check("cmp_out_valid", int'(intf.out_valid), exp_valid);
      check("cmp_data_out", int'(intf.data_out), exp_data);
`ifdef FNS_DEC_FAULT_CHECK_EN
      check("cmp_fault_err", int'(intf.fault_err), exp_fault);
`endif
   end

   task automatic send(input logic [4:0] c, input logic [4:0] e);
      intf.code_in  = c;
      intf.en_flag  = e;
      intf.in_valid = 1'b1;
      for (int k = 0; k < 40; k++) begin
         if (intf.in_ready) begin
            @(negedge clock);
            intf.in_valid = 1'b0;
            return;
         end
         @(negedge clock);
      end
      check("send_timeout", 0, 1);
      intf.in_valid = 1'b0;
   endtask

   task automatic wait_val(input logic v, output int n);
      n = 0;
      while (intf.out_valid !== v && n < 40) begin
         @(negedge clock);
         n++;
      end
      if (intf.out_valid !== v) check("wait_out_valid_timeout", n, -1);
   endtask

   int n, m;

   initial begin
      intf.code_in = '0;  intf.en_flag = '0;  intf.in_valid = 1'b0;  intf.out_ready = 1'b1;
      intf3.code_in = '0; intf3.en_flag = '0; intf3.in_valid = 1'b0; intf3.out_ready = 1'b1;
      repeat (3) @(negedge clock);
      check("reset_in_ready", int'(intf.in_ready), 1);
      check("reset_out_valid", int'(intf.out_valid), 0);
      check("reset_data_out", int'(intf.data_out), 0);
      rst_n = 1'b1;
      @(negedge clock);

      // Basic decode: 5 + 2 = 7.
      send(5'b10100, 5'b11111);
      wait_val(1'b1, n);
      check("accept_to_valid_edges", n, 5);
      check("basic_data", int'(intf.data_out), 7);
`ifdef FNS_DEC_FAULT_CHECK_EN
      check("basic_fault_err", int'(intf.fault_err), 0);
`endif
      wait_val(1'b0, n);

      // Masked TSV; weights changed mid-word must not matter.
      send(5'b11011, 5'b10111);
      f2 = 4'hf; f3 = 4'hf; f4 = 4'hf; f5 = 4'hf;
      wait_val(1'b1, n);
      check("masked_data", int'(intf.data_out), 7);
`ifdef FNS_DEC_FAULT_CHECK_EN
      check("masked_fault_err", int'(intf.fault_err), 1);
`endif
      f2 = 4'd1; f3 = 4'd2; f4 = 4'd3; f5 = 4'd5;
      wait_val(1'b0, n);

      // All TSVs disabled.
      send(5'b11111, 5'b00000);
      wait_val(1'b1, n);
      check("all_disabled_data", int'(intf.data_out), 0);
      wait_val(1'b0, n);

      // Backpressure: 1 + 1 = 2 held while a second word waits.
      intf.out_ready = 1'b0;
      send(5'b00011, 5'b11111);
      wait_val(1'b1, n);
      intf.code_in = 5'b00001; intf.en_flag = 5'b11111; intf.in_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clock);
         check("bp_data_stable", int'(intf.data_out), 2);
         check("bp_in_ready_low", int'(intf.in_ready), 0);
      end
      intf.out_ready = 1'b1;
      @(negedge clock);
      check("bp_release_valid", int'(intf.out_valid), 0);
      check("bp_release_ready", int'(intf.in_ready), 1);
      @(negedge clock);
      check("bp_second_taken", int'(intf.in_ready), 0);
      intf.in_valid = 1'b0;
      wait_val(1'b1, n);
      check("bp_second_data", int'(intf.data_out), 1);
      wait_val(1'b0, n);

      // Throughput with in_valid held and out_ready high: weight of bit 2 is 2.
      intf.code_in = 5'b00100; intf.en_flag = 5'b11111; intf.in_valid = 1'b1;
      wait_val(1'b1, n);
      wait_val(1'b0, n);
      wait_val(1'b1, m);
      intf.in_valid = 1'b0;
      check("word_period", n + m, 7);
      check("tput_data", int'(intf.data_out), 2);
      wait_val(1'b0, n);

      // Reset during the third ACC cycle discards the word.
      send(5'b11111, 5'b11111);
      @(negedge clock);
      @(negedge clock);
      rst_n = 1'b0;
      @(negedge clock);
      rst_n = 1'b1;
      check("midrst_out_valid", int'(intf.out_valid), 0);
      check("midrst_in_ready", int'(intf.in_ready), 1);
      m = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clock);
         if (intf.out_valid) m++;
      end
      check("midrst_no_valid", m, 0);
      check("midrst_data", int'(intf.data_out), 0);

      // Overflow on the 3-bit instance: 12 mod 8 = 4.
      intf3.code_in = 5'b11111; intf3.en_flag = 5'b11111; intf3.in_valid = 1'b1;
      @(negedge clock);
      intf3.in_valid = 1'b0;
      n = 0;
      while (!intf3.out_valid && n < 40) begin
         @(negedge clock);
         n++;
      end
      check("ovf_latency", n, 5);
      check("ovf_data", int'(intf3.data_out), 4);

      repeat (3) @(negedge clock);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
